// File: rtl/instr_fetch_unit_pkg.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit_pkg
//   Definitions shared by the fetch stage and the control unit:
//     - instruction field positions and widths
//     - primary opcode constants
//     - the NOP encoding
//     - the fetch state encoding
//   There are no ports; this is a package.
// ---------------------------------------------------------------------------
package instr_fetch_unit_pkg;

    localparam int unsigned INSTR_BITS = 32;

    // Field positions (LSB) and widths within a 32-bit instruction word
    localparam int unsigned OPCODE_LSB = 26;
    localparam int unsigned OPCODE_W   = 6;
    localparam int unsigned RS_LSB     = 21;
    localparam int unsigned RS_W       = 5;
    localparam int unsigned RT_LSB     = 16;
    localparam int unsigned RT_W       = 5;
    localparam int unsigned RD_LSB     = 11;
    localparam int unsigned RD_W       = 5;
    localparam int unsigned SHAMT_LSB  = 6;
    localparam int unsigned SHAMT_W    = 5;
    localparam int unsigned FUNCT_LSB  = 0;
    localparam int unsigned FUNCT_W    = 6;
    localparam int unsigned IMM16_LSB  = 0;
    localparam int unsigned IMM16_W    = 16;
    localparam int unsigned JADDR_LSB  = 0;
    localparam int unsigned JADDR_W    = 26;

    // Primary opcodes
    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OPCODE_W-1:0] OP_J     = 6'h02;
    localparam logic [OPCODE_W-1:0] OP_JAL   = 6'h03;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OPCODE_W-1:0] OP_BNE   = 6'h05;
    localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OPCODE_W-1:0] OP_LW    = 6'h23;
    localparam logic [OPCODE_W-1:0] OP_SW    = 6'h2B;

    localparam logic [INSTR_BITS-1:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [2:0] {
        FS_IDLE,
        FS_REQ,
        FS_WAIT,
        FS_HOLD,
        FS_HALTED
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_decode.sv
// ---------------------------------------------------------------------------
// instr_field_decode
//   Purely combinational slicing of an instruction word into its fields.
//   Ports:
//     i_instr   in  32  instruction word
//     o_opcode  out 6   [31:26]
//     o_rs      out 5   [25:21]
//     o_rt      out 5   [20:16]
//     o_rd      out 5   [15:11]
//     o_shamt   out 5   [10:6]
//     o_funct   out 6   [5:0]
//     o_imm16   out 16  [15:0]
//     o_jaddr   out 26  [25:0]
// ---------------------------------------------------------------------------
module instr_field_decode
    import instr_fetch_unit_pkg::*;
(
    input  logic [INSTR_BITS-1:0] i_instr,
    output logic [OPCODE_W-1:0]   o_opcode,
    output logic [RS_W-1:0]       o_rs,
    output logic [RT_W-1:0]       o_rt,
    output logic [RD_W-1:0]       o_rd,
    output logic [SHAMT_W-1:0]    o_shamt,
    output logic [FUNCT_W-1:0]    o_funct,
    output logic [IMM16_W-1:0]    o_imm16,
    output logic [JADDR_W-1:0]    o_jaddr
);

    assign o_opcode = i_instr[OPCODE_LSB +: OPCODE_W];
    assign o_rs     = i_instr[RS_LSB     +: RS_W];
    assign o_rt     = i_instr[RT_LSB     +: RT_W];
    assign o_rd     = i_instr[RD_LSB     +: RD_W];
    assign o_shamt  = i_instr[SHAMT_LSB  +: SHAMT_W];
    assign o_funct  = i_instr[FUNCT_LSB  +: FUNCT_W];
    assign o_imm16  = i_instr[IMM16_LSB  +: IMM16_W];
    assign o_jaddr  = i_instr[JADDR_LSB  +: JADDR_W];

endmodule

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//   Fetch stage: owns the PC, reads instruction memory (1-cycle registered
//   read), latches the IR and presents decoded fields with a valid/ready
//   handshake to the control unit.
//   Optional feature macro: IFU_PERF_CNT_EN (fetch/redirect counters).
//   Ports:
//     clk, rst                 clock, synchronous active-high reset
//     im_rd_en, im_addr        memory read request (im_addr = pc)
//     im_rdata                 memory read data (valid cycle after im_rd_en)
//     instr_valid/instr_ready  handshake with the control unit
//     redirect_valid/_pc       next-PC redirect, sampled on accept
//     halt                     stop fetching after current instruction
//     opcode..jaddr            decoded IR fields
//     pc_out, pc_plus4         address of IR instruction, and +4 link value
//     halted                   fetch stopped
//     fetch_count              accepted instructions (0 when feature off)
//     redirect_count           accepted redirects (0 when feature off)
// ---------------------------------------------------------------------------
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int unsigned        ADDR_W   = 32,
    parameter int unsigned        INSTR_W  = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    output logic                im_rd_en,
    output logic [ADDR_W-1:0]   im_addr,
    input  logic [INSTR_W-1:0]  im_rdata,
    output logic                instr_valid,
    input  logic                instr_ready,
    input  logic                redirect_valid,
    input  logic [ADDR_W-1:0]   redirect_pc,
    input  logic                halt,
    output logic [5:0]          opcode,
    output logic [4:0]          rs,
    output logic [4:0]          rt,
    output logic [4:0]          rd,
    output logic [4:0]          shamt,
    output logic [5:0]          funct,
    output logic [15:0]         imm16,
    output logic [25:0]         jaddr,
    output logic [ADDR_W-1:0]   pc_out,
    output logic [ADDR_W-1:0]   pc_plus4,
    output logic                halted,
    output logic [31:0]         fetch_count,
    output logic [31:0]         redirect_count
);

    fetch_state_t          r_state;
    fetch_state_t          w_next_state;
    logic [ADDR_W-1:0]     r_pc;
    logic [INSTR_W-1:0]    r_ir;
    logic                  w_accept;
    logic [ADDR_W-1:0]     w_pc_next;

    assign w_accept  = (r_state == FS_HOLD) && instr_ready;
    // Redirect target is forced word aligned by masking the two low bits
    assign w_pc_next = redirect_valid ? (redirect_pc & ~ADDR_W'(3))
                                      : (r_pc + ADDR_W'(4));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FS_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            FS_IDLE:   w_next_state = FS_REQ;
            FS_REQ:    w_next_state = FS_WAIT;
            FS_WAIT:   w_next_state = FS_HOLD;
            FS_HOLD:   if (instr_ready) w_next_state = halt ? FS_HALTED : FS_REQ;
            FS_HALTED: w_next_state = FS_HALTED;
            default:   w_next_state = FS_IDLE;
        endcase
    end

    // Outputs decoded from the state register
    always_comb begin
        im_rd_en    = 1'b0;
        instr_valid = 1'b0;
        halted      = 1'b0;
        case (r_state)
            FS_REQ:    im_rd_en    = 1'b1;
            FS_HOLD:   instr_valid = 1'b1;
            FS_HALTED: halted      = 1'b1;
            default:   ;
        endcase
    end

    // PC and IR; a halting accept leaves the PC on the halted instruction
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_PC;
            r_ir <= '0;
        end else begin
            if (r_state == FS_WAIT) begin
                r_ir <= im_rdata;
            end
            if (w_accept && !halt) begin
                r_pc <= w_pc_next;
            end
        end
    end

    assign im_addr  = r_pc;
    assign pc_out   = r_pc;
    assign pc_plus4 = r_pc + ADDR_W'(4);

    instr_field_decode u_decode (
        .i_instr  (r_ir),
        .o_opcode (opcode),
        .o_rs     (rs),
        .o_rt     (rt),
        .o_rd     (rd),
        .o_shamt  (shamt),
        .o_funct  (funct),
        .o_imm16  (imm16),
        .o_jaddr  (jaddr)
    );

`ifdef IFU_PERF_CNT_EN
    logic [31:0] r_fetch_count;
    logic [31:0] r_redirect_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_count    <= '0;
            r_redirect_count <= '0;
        end else if (w_accept) begin
            r_fetch_count <= r_fetch_count + 32'd1;
            if (redirect_valid && !halt) begin
                r_redirect_count <= r_redirect_count + 32'd1;
            end
        end
    end

    assign fetch_count    = r_fetch_count;
    assign redirect_count = r_redirect_count;
`else
    assign fetch_count    = '0;
    assign redirect_count = '0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        im_rd_en;
    logic [31:0] im_addr;
    logic [31:0] im_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
    logic [5:0]  opcode;
    logic [4:0]  rs, rt, rd, shamt;
    logic [5:0]  funct;
    logic [15:0] imm16;
    logic [25:0] jaddr;
    logic [31:0] pc_out, pc_plus4;
    logic        halted;
    logic [31:0] fetch_count, redirect_count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .ADDR_W   (32),
        .INSTR_W  (32),
        .RESET_PC (32'h0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .im_rd_en       (im_rd_en),
        .im_addr        (im_addr),
        .im_rdata       (im_rdata),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .opcode         (opcode),
        .rs             (rs),
        .rt             (rt),
        .rd             (rd),
        .shamt          (shamt),
        .funct          (funct),
        .imm16          (imm16),
        .jaddr          (jaddr),
        .pc_out         (pc_out),
        .pc_plus4       (pc_plus4),
        .halted         (halted),
        .fetch_count    (fetch_count),
        .redirect_count (redirect_count)
    );

    // Memory contents: word 0 is fixed, everything else a scrambled address
    function automatic logic [31:0] memword(input logic [31:0] a);
        if (a == 32'h0) return 32'h0022_1820;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Registered-read instruction memory
    always @(posedge clk) begin
        if (im_rd_en) im_rdata <= memword(im_addr);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction-level model: after reset or an accept, a fetch is launched.
    // m_req is the edge after which the read request is visible; the IR
    // loads two edges later and the instruction is then held until accepted.
    int          edges = 0;
    int          m_req = 1000000;
    bit          m_live = 0;
    bit          m_halt = 0;
    logic [31:0] m_pc = 0, m_ir = 0, m_fc = 0, m_rc = 0;

    always @(posedge clk) begin
        bit holding;
        holding = m_live && !m_halt && (edges >= m_req + 2);
        edges++;
        if (rst) begin
            m_live = 1; m_halt = 0; m_pc = 0; m_ir = 0; m_fc = 0; m_rc = 0;
            m_req  = edges + 1;
        end else if (holding && instr_ready) begin
            m_fc++;
            if (halt) begin
                m_halt = 1;
            end else begin
                if (redirect_valid) begin
                    m_rc++;
                    m_pc = redirect_pc & 32'hFFFF_FFFC;
                end else begin
                    m_pc = m_pc + 32'd4;
                end
                m_req = edges;
            end
        end else if (m_live && !m_halt && edges == m_req + 2) begin
            m_ir = memword(m_pc);
        end
    end

    // Per-cycle compare against the model
    always @(negedge clk) begin
        if (m_live) begin
            chk("im_rd_en",    32'(im_rd_en),    32'(!m_halt && edges == m_req));
            chk("instr_valid", 32'(instr_valid), 32'(!m_halt && edges >= m_req + 2));
            chk("halted",      32'(halted),      32'(m_halt));
            chk("im_addr",     im_addr,          m_pc);
            chk("pc_out",      pc_out,           m_pc);
            chk("pc_plus4",    pc_plus4,         m_pc + 32'd4);
            chk("opcode",      32'(opcode),      32'(m_ir[31:26]));
            chk("rs",          32'(rs),          32'(m_ir[25:21]));
            chk("rt",          32'(rt),          32'(m_ir[20:16]));
            chk("rd",          32'(rd),          32'(m_ir[15:11]));
            chk("shamt",       32'(shamt),       32'(m_ir[10:6]));
            chk("funct",       32'(funct),       32'(m_ir[5:0]));
            chk("imm16",       32'(imm16),       32'(m_ir[15:0]));
            chk("jaddr",       32'(jaddr),       32'(m_ir[25:0]));
`ifdef IFU_PERF_CNT_EN
            chk("fetch_count",    fetch_count,    m_fc);
            chk("redirect_count", redirect_count, m_rc);
`else
            chk("fetch_count",    fetch_count,    32'd0);
            chk("redirect_count", redirect_count, 32'd0);
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_valid(input string nm);
        for (int i = 0; i < 8; i++) begin
            if (instr_valid) break;
            step();
        end
        chk(nm, 32'(instr_valid), 32'd1);
    endtask

    task automatic accept(input logic rv, input logic [31:0] rpc, input logic h);
        instr_ready = 1'b1; redirect_valid = rv; redirect_pc = rpc; halt = h;
        step();
        instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; halt = 1'b0;
    endtask

    initial begin
        rst = 1'b1; instr_ready = 1'b0; redirect_valid = 1'b0;
        redirect_pc = 32'h0; halt = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst pc_plus4", pc_plus4, 32'd4);
        chk("rst valid",    32'(instr_valid), 32'd0);
        rst = 1'b0;

        // 1: first fetch latency and field decode
        step();
        chk("t1 rd_en@2", 32'(im_rd_en), 32'd1);
        step(); step();
        chk("t1 valid@4", 32'(instr_valid), 32'd1);
        chk("t1 opcode",  32'(opcode), 32'd0);
        chk("t1 rs",      32'(rs),     32'd1);
        chk("t1 rt",      32'(rt),     32'd2);
        chk("t1 rd",      32'(rd),     32'd3);
        chk("t1 funct",   32'(funct),  32'h20);
        chk("t1 pc_out",  pc_out,      32'd0);
        chk("t1 pc_plus4", pc_plus4,   32'd4);

        // 2: hold off ready, everything stays put
        repeat (10) step();
        chk("t2 imm16 stable", 32'(imm16), 32'h1820);
        chk("t2 pc stable",    pc_out, 32'd0);
        accept(1'b0, 32'h0, 1'b0);
        chk("t2 im_addr", im_addr, 32'd4);
        chk("t2 rd_en",   32'(im_rd_en), 32'd1);

        // 3: redirect with misaligned target
        wait_valid("t3 wait");
        accept(1'b1, 32'h43, 1'b0);
        chk("t3 im_addr", im_addr, 32'h40);
`ifdef IFU_PERF_CNT_EN
        chk("t3 redirect_count", redirect_count, 32'd1);
`endif

        // ready held high through REQ/WAIT: only HOLD cycles accept
        instr_ready = 1'b1;
        repeat (12) step();
        instr_ready = 1'b0;

        // 4: pc wraps from 0xFFFFFFFC to 0
        wait_valid("t4 wait a");
        accept(1'b1, 32'hFFFF_FFFF, 1'b0);
        chk("t4 aligned", im_addr, 32'hFFFF_FFFC);
        wait_valid("t4 wait b");
        chk("t4 pc_plus4 wrap", pc_plus4, 32'h0);
        accept(1'b0, 32'h0, 1'b0);
        chk("t4 im_addr wrap", im_addr, 32'h0);

        // 5: halt beats redirect
        wait_valid("t5 wait");
        accept(1'b1, 32'h100, 1'b1);
        chk("t5 halted", 32'(halted), 32'd1);
        chk("t5 pc_out", pc_out, 32'h0);
        instr_ready = 1'b1;
        repeat (5) step();
        instr_ready = 1'b0;
        chk("t5 still halted", 32'(halted), 32'd1);
        chk("t5 no rd_en",     32'(im_rd_en), 32'd0);

        // 6: reset during WAIT discards the in-flight read
        rst = 1'b1; step(); rst = 1'b0;
        step(); step();
        chk("t6 in wait", 32'(instr_valid | im_rd_en | halted), 32'd0);
        rst = 1'b1; step();
        chk("t6 ir zero",   32'(jaddr), 32'd0);
        chk("t6 pc reset",  pc_out, 32'd0);
        chk("t6 fc zero",   fetch_count, 32'd0);
        chk("t6 rc zero",   redirect_count, 32'd0);
        rst = 1'b0;
        step(); step(); step();
        chk("t6 refetch valid", 32'(instr_valid), 32'd1);
        chk("t6 refetch imm16", 32'(imm16), 32'h1820);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
